operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk_pi, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_pi, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port data_pi, input, WIDTH bits, the shared operand bus (switches).
REQ-005 The block SHALL have port load_pi, input, 1 bit, a level load request; only its rising edge acts.
REQ-006 The block SHALL have port clear_pi, input, 1 bit, a synchronous abort to S_LOAD_A.
REQ-007 The block SHALL have port A_po, output, WIDTH bits, the registered operand A driven to the adder A_pi.
REQ-008 The block SHALL have port B_po, output, WIDTH bits, the registered operand B driven to the adder B_pi.
REQ-009 The block SHALL have port sum_pi, input, WIDTH+1 bits, the adder result_po, MSB being carry-out.
REQ-010 The block SHALL have port result_po, output, WIDTH+1 bits, the registered sum.
REQ-011 The block SHALL have port valid_po, output, 1 bit, high while result_po holds a sum of the current A_po/B_po.
REQ-012 The block SHALL have port state_po, output, 2 bits, the current state encoding, for LEDs and debug.

Function
REQ-013 The block SHALL detect a load event as load_pi high in this cycle and low in the previous registered sample; a held level SHALL produce exactly one event.
REQ-014 The FSM SHALL have states S_LOAD_A=0, S_LOAD_B=1, S_CALC=2 and S_DONE=3.
REQ-015 In S_LOAD_A, a load event SHALL capture data_pi into A_po and move to S_LOAD_B.
REQ-016 In S_LOAD_B, a load event SHALL capture data_pi into B_po and move to S_CALC.
REQ-017 S_CALC SHALL last exactly one cycle, capture sum_pi into result_po, set valid_po, and move to S_DONE; latency from the B load edge to valid_po high is 2 clock cycles.
REQ-018 In S_DONE, result_po and valid_po SHALL hold; a load event SHALL capture data_pi into A_po, clear valid_po, and move to S_LOAD_B.
REQ-019 Load events in S_CALC SHALL be ignored.
REQ-020 A_po and B_po SHALL change only on their own load events, so the adder inputs are stable through S_CALC.
REQ-021 clear_pi SHALL move the FSM to S_LOAD_A, zero A_po, B_po and result_po, and clear valid_po on the next edge.
REQ-022 clear_pi SHALL win over a simultaneous load event, and that load event SHALL be discarded.
REQ-023 result_po SHALL be the full WIDTH+1 bits of sum_pi without truncation; the carry-out SHALL be preserved, so the sum never overflows.

Reset
REQ-024 With rst_n_pi low, the block SHALL asynchronously set the state to S_LOAD_A, A_po=B_po=0, result_po=0, valid_po=0, state_po=0, and the load-edge history register to 1.
REQ-025 Because the history register resets to 1, a load_pi already high at reset release SHALL generate no event.
REQ-026 Reset asserted mid-operation, in any state, SHALL abort immediately and discard any partially loaded operands.

Structure
REQ-027 A shared package rca_pkg SHALL hold the state enum typedef (2-bit) and the state encodings.
REQ-028 Rising-edge detection SHALL be a sub-module, edge_detect, with clk_pi, rst_n_pi, a level input and a one-cycle pulse output.
REQ-029 The block SHALL contain no arithmetic; the sum SHALL come only through sum_pi from the external param_rca instance.

Verification
REQ-030 With WIDTH=4, loading A=4'h3 then B=4'h5 SHALL give result_po=5'h08 and valid_po=1 two cycles after the B edge.
REQ-031 Loading A=4'hF then B=4'hF SHALL give result_po=5'h1E, with the carry bit set.
REQ-032 Holding load_pi high for 10 cycles in S_LOAD_A SHALL capture A only, leaving state_po=1 and B_po unchanged.
REQ-033 clear_pi and a load edge together in S_LOAD_B SHALL give state_po=0 and A_po=B_po=result_po=0 on the next cycle.
REQ-034 A load edge in S_DONE with data_pi=4'h7 SHALL give A_po=4'h7, valid_po=0, state_po=1, with result_po holding its old value.
REQ-035 rst_n_pi pulsed low in S_CALC SHALL zero all outputs asynchronously, and a load_pi held high across reset release SHALL produce no capture.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry-adder front end: the operand
// sequencer state encoding.
package rca_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when the level goes high after
// having been sampled low on the previous clock edge.
module edge_detect (
    input  logic clk_pi,
    input  logic rst_n_pi,
    input  logic level_pi,
    output logic pulse_po
);

    logic prev;

    // History resets high, so a level already asserted at reset release
    // is treated as old and produces no pulse.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            prev <= level_pi;
        end
    end

    assign pulse_po = level_pi & ~prev;

endmodule

// File: rtl/operand_sequencer.sv
// Sequences two operands off a shared switch bus into an external adder
// and registers its WIDTH+1-bit result, carry included.
module operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic [WIDTH-1:0] data_pi,
    input  logic             load_pi,
    input  logic             clear_pi,
    output logic [WIDTH-1:0] A_po,
    output logic [WIDTH-1:0] B_po,
    input  logic [WIDTH:0]   sum_pi,
    output logic [WIDTH:0]   result_po,
    output logic             valid_po,
    output logic [1:0]       state_po
);

    import rca_pkg::*;

    state_t state;
    state_t next_state;
    logic   load_event;
    logic   load_a;
    logic   load_b;
    logic   capture;

    edge_detect u_load_edge (
        .clk_pi   (clk_pi),
        .rst_n_pi (rst_n_pi),
        .level_pi (load_pi),
        .pulse_po (load_event)
    );

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state <= S_LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        if (clear_pi) begin
            // Abort wins; a coincident load event is simply dropped.
            next_state = S_LOAD_A;
        end else begin
            unique case (state)
                S_LOAD_A: if (load_event) begin
                    load_a     = 1'b1;
                    next_state = S_LOAD_B;
                end
                S_LOAD_B: if (load_event) begin
                    load_b     = 1'b1;
                    next_state = S_CALC;
                end
                S_CALC: begin
                    capture    = 1'b1;
                    next_state = S_DONE;
                end
                S_DONE: if (load_event) begin
                    load_a     = 1'b1;
                    next_state = S_LOAD_B;
                end
                default: next_state = S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            A_po      <= '0;
            B_po      <= '0;
            result_po <= '0;
            valid_po  <= 1'b0;
        end else if (clear_pi) begin
            A_po      <= '0;
            B_po      <= '0;
            result_po <= '0;
            valid_po  <= 1'b0;
        end else begin
            if (load_a) begin
                A_po     <= data_pi;
                valid_po <= 1'b0;
            end
            if (load_b) begin
                B_po <= data_pi;
            end
            if (capture) begin
                result_po <= sum_pi;
                valid_po  <= 1'b1;
            end
        end
    end

    assign state_po = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural adder standing in
// for the external param_rca instance.
module tb_operand_sequencer;

    localparam int WIDTH = 4;

    logic             clk_pi = 1'b0;
    logic             rst_n_pi;
    logic [WIDTH-1:0] data_pi;
    logic             load_pi;
    logic             clear_pi;
    logic [WIDTH-1:0] A_po;
    logic [WIDTH-1:0] B_po;
    logic [WIDTH:0]   sum_pi;
    logic [WIDTH:0]   result_po;
    logic             valid_po;
    logic [1:0]       state_po;

    int checks   = 0;
    int failures = 0;

    operand_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_pi    (clk_pi),
        .rst_n_pi  (rst_n_pi),
        .data_pi   (data_pi),
        .load_pi   (load_pi),
        .clear_pi  (clear_pi),
        .A_po      (A_po),
        .B_po      (B_po),
        .sum_pi    (sum_pi),
        .result_po (result_po),
        .valid_po  (valid_po),
        .state_po  (state_po)
    );

    // External adder model.
    assign sum_pi = {1'b0, A_po} + {1'b0, B_po};

    always #5 clk_pi = ~clk_pi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pi);
        #1;
    endtask

    // Raise load for exactly one sampled edge, then drop it.
    task automatic pulse_load(input logic [WIDTH-1:0] d);
        data_pi = d;
        load_pi = 1'b1;
        tick();
        load_pi = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] a,
                             input logic [3:0] b, input logic [4:0] res, input logic v);
        check({tag, ".state"},  32'(state_po),  32'(st));
        check({tag, ".A"},      32'(A_po),      32'(a));
        check({tag, ".B"},      32'(B_po),      32'(b));
        check({tag, ".result"}, 32'(result_po), 32'(res));
        check({tag, ".valid"},  32'(valid_po),  32'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_pi = 1'b0;
        data_pi  = '0;
        load_pi  = 1'b0;
        clear_pi = 1'b0;
        tick();
        check_all("reset", 2'd0, 4'h0, 4'h0, 5'h00, 1'b0);
        rst_n_pi = 1'b1;
        tick();

        // 3 + 5: B captured on the first edge, result valid on the next.
        pulse_load(4'h3);
        check_all("load_a3", 2'd1, 4'h3, 4'h0, 5'h00, 1'b0);
        tick();
        pulse_load(4'h5);
        check_all("load_b5", 2'd2, 4'h3, 4'h5, 5'h00, 1'b0);
        tick();
        check_all("calc_3p5", 2'd3, 4'h3, 4'h5, 5'h08, 1'b1);
        tick();
        check_all("done_hold", 2'd3, 4'h3, 4'h5, 5'h08, 1'b1);

        // Load in S_DONE reloads A, drops valid, keeps the old result.
        pulse_load(4'h7);
        check_all("done_load7", 2'd1, 4'h7, 4'h5, 5'h08, 1'b0);
        tick();
        pulse_load(4'hF);
        tick();
        check_all("calc_7pF", 2'd3, 4'h7, 4'hF, 5'h16, 1'b1);

        clear_pi = 1'b1;
        tick();
        clear_pi = 1'b0;
        check_all("clear_done", 2'd0, 4'h0, 4'h0, 5'h00, 1'b0);

        // F + F: carry-out must survive into result bit 4.
        pulse_load(4'hF);
        tick();
        pulse_load(4'hF);
        tick();
        check_all("calc_FpF", 2'd3, 4'hF, 4'hF, 5'h1E, 1'b1);

        clear_pi = 1'b1;
        tick();
        clear_pi = 1'b0;

        // Held load level: one capture only, later data ignored.
        data_pi = 4'h9;
        load_pi = 1'b1;
        tick();
        data_pi = 4'h6;
        for (int i = 0; i < 9; i++) tick();
        check_all("held_load", 2'd1, 4'h9, 4'h0, 5'h00, 1'b0);
        load_pi = 1'b0;
        tick();

        // Clear with a coincident load edge in S_LOAD_B.
        data_pi  = 4'h4;
        load_pi  = 1'b1;
        clear_pi = 1'b1;
        tick();
        clear_pi = 1'b0;
        check_all("clear_vs_load", 2'd0, 4'h0, 4'h0, 5'h00, 1'b0);
        load_pi = 1'b0;
        tick();
        check("clear_vs_load.discarded", 32'(state_po), 32'd0);

        // Load held across a CALC/DONE sequence produces no extra capture.
        pulse_load(4'h1);
        tick();
        data_pi = 4'h2;
        load_pi = 1'b1;
        tick();
        check("held_b.state", 32'(state_po), 32'd2);
        data_pi = 4'hC;
        tick();
        tick();
        check_all("held_through_done", 2'd3, 4'h1, 4'h2, 5'h03, 1'b1);
        load_pi = 1'b0;
        tick();

        // Asynchronous reset while in S_CALC, load held across release.
        clear_pi = 1'b1;
        tick();
        clear_pi = 1'b0;
        pulse_load(4'h3);
        tick();
        pulse_load(4'h4);
        check("pre_reset.state", 32'(state_po), 32'd2);
        #2;
        rst_n_pi = 1'b0;
        load_pi  = 1'b1;
        data_pi  = 4'hA;
        #1;
        check_all("async_reset", 2'd0, 4'h0, 4'h0, 5'h00, 1'b0);
        tick();
        rst_n_pi = 1'b1;
        tick();
        tick();
        check_all("reset_release_held", 2'd0, 4'h0, 4'h0, 5'h00, 1'b0);
        load_pi = 1'b0;
        tick();
        pulse_load(4'h2);
        check_all("after_reset_load", 2'd1, 4'h2, 4'h0, 5'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
